// File: rtl/urt_pkg.sv
// Shared URT link definitions: FSM states, frame bit levels and parity types.
// Used by both the transmitter and the receiver.
package urt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } urt_state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/urt_tx_if.sv
// Parallel request side plus serial line of the URT transmitter.
interface urt_tx_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 5
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [PRESC_W-1:0]    Prescale;
   logic                  TX_OUT;
   logic                  Busy;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
      input  TX_OUT, Busy
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
      output TX_OUT, Busy
   );
endinterface

// File: rtl/urt_parity_calc.sv
// Combinational parity generator, shared with the receiver's parity checker.
module urt_parity_calc
   import urt_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);
   assign par_bit = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/urt_tx.sv
// URT UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Define URT_TX_HOLD_EN to add a one-entry holding register for gapless frames.
module urt_tx
   import urt_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 5
) (
   input  logic   CLK,
   input  logic   RST,
   urt_tx_if.slave bus
);
   localparam int IDX_W = $clog2(DATA_WIDTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  par_en;
      logic                  par_typ;
      logic [PRESC_W-1:0]    presc;
   } frame_t;

   urt_state_e         state_q, state_d;
   logic [PRESC_W-1:0] cnt_q, cnt_d, presc_last;
   logic [IDX_W-1:0]   idx_q, idx_d;
   frame_t             frm_q, frm_d, req;
   logic               tx_q, tx_d, busy_q, busy_d;
   logic               accept, bit_end, frame_end, par_bit;
`ifdef URT_TX_HOLD_EN
   frame_t             hold_q, hold_d;
   logic               hold_vld_q, hold_vld_d;
`endif

   assign req        = {bus.P_DATA, bus.PAR_EN, bus.PAR_TYP, bus.Prescale};
   assign accept     = bus.Data_Valid && !busy_q;
   // A prescale of 0 behaves as 1: the bit ends when the counter sits at 0.
   assign presc_last = (frm_q.presc == '0) ? '0 : frm_q.presc - 1'b1;
   assign bit_end    = (cnt_q == presc_last);
   assign frame_end  = (state_q == ST_STOP) && bit_end;

   urt_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
      .data    (frm_q.data),
      .par_typ (frm_q.par_typ),
      .par_bit (par_bit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      frm_d   = frm_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
`ifdef URT_TX_HOLD_EN
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (accept && state_q != ST_IDLE && !frame_end) begin
         hold_d     = req;
         hold_vld_d = 1'b1;
         busy_d     = 1'b1;
      end
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (accept) begin
               frm_d   = req;
               state_d = ST_START;
               tx_d    = START_BIT;
`ifndef URT_TX_HOLD_EN
               busy_d  = 1'b1;
`endif
            end
         end
         ST_START: if (bit_end) begin
            state_d = ST_DATA;
            idx_d   = '0;
            tx_d    = frm_q.data[0];
         end
         ST_DATA: if (bit_end) begin
            if (idx_q == IDX_W'(DATA_WIDTH-1)) begin
               if (frm_q.par_en) begin
                  state_d = ST_PARITY;
                  tx_d    = par_bit;
               end else begin
                  state_d = ST_STOP;
                  tx_d    = STOP_BIT;
               end
            end else begin
               idx_d = idx_q + 1'b1;
               tx_d  = frm_q.data[idx_q + 1'b1];
            end
         end
         ST_PARITY: if (bit_end) begin
            state_d = ST_STOP;
            tx_d    = STOP_BIT;
         end
         ST_STOP: if (bit_end) begin
            state_d = ST_IDLE;
            tx_d    = STOP_BIT;
            busy_d  = 1'b0;
`ifdef URT_TX_HOLD_EN
            // Chain straight into the next start bit, no idle cycle.
            if (hold_vld_q) begin
               frm_d      = hold_q;
               hold_vld_d = 1'b0;
               state_d    = ST_START;
               tx_d       = START_BIT;
            end else if (accept) begin
               frm_d   = req;
               state_d = ST_START;
               tx_d    = START_BIT;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = STOP_BIT;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         frm_q      <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
`ifdef URT_TX_HOLD_EN
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         frm_q      <= frm_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
`ifdef URT_TX_HOLD_EN
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
`endif
      end
   end

   assign bus.TX_OUT = tx_q;
   assign bus.Busy   = busy_q;

endmodule

// File: doc/urt_tx.md
# urt_tx

UART transmitter for the URT link, the stage directly upstream of the URT receiver on the serial line. Accepts one parallel byte per handshake, frames it as start bit, 8 data bits LSB first, optional parity bit, and one stop bit, and drives the frame on `TX_OUT`. The bit rate comes from the same fast clock and `Prescale` value the receiver uses, so a looped-back `urt_tx` → receiver pair recovers the byte exactly.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `PRESC_W`, 5, width of `Prescale`.
- `CLK`, in, 1, single clock, all logic on its rising edge.
- `RST`, in, 1, reset, synchronous and active-high.
- `P_DATA`, in, DATA_WIDTH, byte to transmit.
- `Data_Valid`, in, 1, request to send `P_DATA`.
- `PAR_EN`, in, 1, 1 = parity bit is inserted.
- `PAR_TYP`, in, 1, 0 = even parity, 1 = odd parity.
- `Prescale`, in, PRESC_W, clock cycles per serial bit.
- `TX_OUT`, out, 1, serial line, registered, idle high.
- `Busy`, out, 1, registered, 1 = new request is not accepted.

## Operation
- Registered FSM with five states:
  - `IDLE`: goes to `START` on a sampled accept.
  - `START`: goes to `DATA` after P cycles.
  - `DATA`: goes to `PARITY` or `STOP` after 8·P cycles.
  - `PARITY`: goes to `STOP` after P cycles.
  - `STOP`: goes to `IDLE` after P cycles.
- Accept condition: `Data_Valid`=1 and `Busy`=0 at the edge, with `RST`=0.
- On accept, `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale` are latched. Input changes mid-frame have no effect.
- Bit period P = latched `Prescale`. A value of 0 is treated as 1.
- A 5-bit cycle counter counts 0..P-1 within each bit. A 3-bit index selects the data bit, LSB first.
- Parity is computed on the latched byte:
  - Even: XOR of the data bits, so the total count of ones is even.
  - Odd: the inverse of the even-parity bit.
- `Data_Valid` while `Busy`=1 is ignored, with no queueing. The exception is `URT_TX_HOLD_EN`, described under Configuration.
- Reset values: `TX_OUT`=1, `Busy`=0, state `IDLE`, counters 0, holding register empty.
- `RST` mid-frame: the frame is abandoned. `TX_OUT`=1 and `Busy`=0 from the reset edge.

## Timing
- Accept at edge k: `TX_OUT`=0 and `Busy`=1 from edge k.
- Data bit i is driven from edge k+(1+i)·P.
- Parity bit, when enabled, is driven from k+9·P.
- Stop bit is driven from k+(9+PE)·P, where PE = latched `PAR_EN`.
- Frame ends at edge E = k+(10+PE)·P: state returns to `IDLE`, `Busy`=0 and `TX_OUT` stays 1.
- Earliest next accept is edge E+1, so frames are separated by at least one idle-high cycle.
- Frame length is (10+PE)·P cycles. At P=8 this is 80 or 88 cycles.

## Configuration
- Macro `URT_TX_HOLD_EN`.
- Defined: a one-entry holding register holds data plus configuration.
  - `Busy` means the holding register is full.
  - During a frame, an accept fills the holding register.
  - At edge E with the holding register full, the next start bit is driven from E with zero idle cycles. The holding register empties and `Busy` drops at E.
  - With the frame register idle, an accept starts transmission directly and the holding register stays empty.
- Undefined: no holding register. Behaviour is exactly as described above.

## Structure
- Package `urt_pkg`:
  - FSM state enum typedef.
  - Frame constants: start=0, stop=1, data bit count 8.
  - Parity-type constants: `PAR_EVEN`=0, `PAR_ODD`=1.
  - Shared with the receiver.
- Sub-module `urt_parity_calc`: combinational, inputs data and type, output parity bit. Reusable by the receiver's parity checker.
- FSM, bit counter, serializer mux and optional holding register live in `urt_tx`.

## Test plan
- Prescale=8, `PAR_EN`=1, `PAR_TYP`=1, `P_DATA`=0x45 → `TX_OUT` bit sequence 0,1,0,1,0,0,0,1,0,0,1, each bit 8 cycles, `Busy` high for 88 cycles.
- Prescale=8, `PAR_EN`=1, `PAR_TYP`=0, `P_DATA`=0xD6 → data bits 0,1,1,0,1,0,1,1, parity bit 1, stop bit 1.
- Prescale=16, `PAR_EN`=0, `P_DATA`=0xFF → 10-bit frame, 160 cycles. A second `Data_Valid` pulse at cycle 40 with 0x00 is ignored.
- `RST` asserted at cycle 30 of a frame → `TX_OUT`=1 and `Busy`=0 from that edge. A new accept afterwards sends a clean frame.
- With `URT_TX_HOLD_EN`, two bytes 0x45 then 0xD6 requested back-to-back at Prescale=8 → the second start bit begins exactly at edge E of the first frame, 176 contiguous cycles in total.
- Loopback into the URT receiver at Prescale=8 with 0x45 (odd parity) and 0xD6 (even parity) → receiver `P_DATA` matches on each `data_valid`.
